io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Two-master IO bus arbiter; each transfer runs IDLE (grant) -> ACCESS (bus cycle) -> DONE (ack).
// Define IO_ARB_RR_EN for round-robin arbitration; without it, master 0 has fixed priority.
module io_bus_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [15:2] m0_adr,
   input  logic [15:0] m0_wdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [15:2] m1_adr,
   input  logic [15:0] m1_wdata,
   output logic        m0_ack,
   output logic [15:0] m0_rdata,
   output logic        m1_ack,
   output logic [15:0] m1_rdata,
   output logic        dma_io_we,
   output logic [15:2] dma_io_wadr,
   output logic [15:2] dma_io_radr,
   output logic [15:0] dma_io_wdata,
   input  logic [15:0] dma_io_rdata,
   output logic        arb_busy
);

`ifdef IO_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_owner;
   logic        r_last_grant;
   logic        r_cmd_we;
   logic [15:2] r_cmd_adr;
   logic [15:0] r_cmd_wdata;
   logic [15:0] r_rdata;
   logic        r_io_we;
   logic        r_m0_ack;
   logic        r_m1_ack;
   logic        r_busy;

   logic        w_any_req;
   logic        w_pick_m1;
   logic        w_win_we;
   logic [15:2] w_win_adr;
   logic [15:0] w_win_wdata;

   assign w_any_req   = m0_req | m1_req;
   // m1 wins when it asks alone, or on a conflict when round-robin says m0 went last
   assign w_pick_m1   = m1_req & (~m0_req | (RR_EN & ~r_last_grant));
   assign w_win_we    = w_pick_m1 ? m1_we    : m0_we;
   assign w_win_adr   = w_pick_m1 ? m1_adr   : m0_adr;
   assign w_win_wdata = w_pick_m1 ? m1_wdata : m0_wdata;

   // NOTE: state and outputs use non-blocking assignments under an async reset so that
   // every register samples pre-edge values and the reset clears them without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cmd_we     <= 1'b0;
         r_cmd_adr    <= '0;
         r_cmd_wdata  <= '0;
         r_rdata      <= '0;
         r_io_we      <= 1'b0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state      <= S_ACCESS;
                  r_owner      <= w_pick_m1;
                  r_last_grant <= w_pick_m1;
                  r_cmd_we     <= w_win_we;
                  r_cmd_adr    <= w_win_adr;
                  r_cmd_wdata  <= w_win_wdata;
                  r_io_we      <= w_win_we;
                  r_busy       <= 1'b1;
               end
            end
            S_ACCESS: begin
               r_state  <= S_DONE;
               r_io_we  <= 1'b0;
               r_rdata  <= r_cmd_we ? 16'h0000 : dma_io_rdata;
               r_m0_ack <= ~r_owner;
               r_m1_ack <= r_owner;
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_m0_ack <= 1'b0;
               r_m1_ack <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state  <= S_IDLE;
               r_io_we  <= 1'b0;
               r_m0_ack <= 1'b0;
               r_m1_ack <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign dma_io_we    = r_io_we;
   assign dma_io_wadr  = r_cmd_adr;
   assign dma_io_radr  = r_cmd_adr;
   assign dma_io_wdata = r_cmd_wdata;
   assign m0_ack       = r_m0_ack;
   assign m1_ack       = r_m1_ack;
   assign m0_rdata     = r_rdata;
   assign m1_rdata     = r_rdata;
   assign arb_busy     = r_busy;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: transaction-timeline model plus directed and random traffic.
// Honours IO_ARB_RR_EN the same way as the design.
module tb_io_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:2] m0_adr, m1_adr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [15:0] m0_rdata, m1_rdata;
   logic        dma_io_we;
   logic [15:2] dma_io_wadr, dma_io_radr;
   logic [15:0] dma_io_wdata, dma_io_rdata;
   logic        arb_busy;

   always #5 clk = ~clk;

   io_bus_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_radr(dma_io_radr),
      .dma_io_wdata(dma_io_wdata), .dma_io_rdata(dma_io_rdata), .arb_busy(arb_busy)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral chain: unwritten words read back as their byte address
   logic [15:0] pmem [16384];
   bit          pwr  [16384];
   assign dma_io_rdata = pwr[dma_io_radr] ? pmem[dma_io_radr] : {dma_io_radr, 2'b00};
   always @(posedge clk) begin
      if (dma_io_we) begin
         pmem[dma_io_wadr] <= dma_io_wdata;
         pwr[dma_io_wadr]  <= 1'b1;
      end
   end

   // Master drivers: hold each command until its ack is seen, then move to the next one
   typedef struct {
      logic        we;
      logic [15:2] adr;
      logic [15:0] wdata;
      int          gap;
      bit          glitch;
   } cmd_t;

   cmd_t q0[$], q1[$];
   cmd_t h0, h1;
   bit   ack_seen0, ack_seen1, glit0, glit1;

   always @(posedge clk) begin
      #1;
      if (m0_req && (ack_seen0 || glit0)) void'(q0.pop_front());
      m0_req = 1'b0;
      glit0  = 1'b0;
      if (q0.size() != 0) begin
         h0 = q0[0];
         if (h0.gap > 0) begin
            h0.gap = h0.gap - 1;
            q0[0]  = h0;
         end else begin
            m0_req = 1'b1; m0_we = h0.we; m0_adr = h0.adr; m0_wdata = h0.wdata; glit0 = h0.glitch;
         end
      end
      if (m1_req && (ack_seen1 || glit1)) void'(q1.pop_front());
      m1_req = 1'b0;
      glit1  = 1'b0;
      if (q1.size() != 0) begin
         h1 = q1[0];
         if (h1.gap > 0) begin
            h1.gap = h1.gap - 1;
            q1[0]  = h1;
         end else begin
            m1_req = 1'b1; m1_we = h1.we; m1_adr = h1.adr; m1_wdata = h1.wdata; glit1 = h1.glitch;
         end
      end
   end

   // Reference model: a grant in IDLE cycle g puts the strobe in g+1 and the ack in g+2
   int          g_cyc = -100;
   logic        mwe, mown;
   logic [15:2] madr;
   logic [15:0] mwd, mrd;
`ifdef IO_ARB_RR_EN
   logic        mlast = 1'b1;
`endif
   logic [15:0] shadow [16384];
   bit          shw    [16384];

   int   ack_cnt0 = 0, ack_cnt1 = 0, we_cnt = 0, ack_cyc0 = 0;
   logic [15:2] last_wadr;
   logic [15:0] last_wdata, last_rd0, last_rd1;
   int   ack_order[$];
   int   ackc_log0[$];
   logic [15:0] rd_log0[$];

   initial begin
      mwe = 1'b0; mown = 1'b0; madr = '0; mwd = '0; mrd = '0;
   end

   always @(negedge clk) begin
      bit   in_acc, in_done, win, wwe;
      logic [15:2] wadr;
      logic [15:0] wwd;
      ack_seen0 = m0_ack;
      ack_seen1 = m1_ack;
      if (!rst_n) begin
         check("rst_ctrl", {arb_busy, dma_io_we, m0_ack, m1_ack}, 4'b0000);
         check("rst_bus", {dma_io_wadr, dma_io_radr, dma_io_wdata}, 44'h0);
         check("rst_rdata", {m0_rdata, m1_rdata}, 32'h0);
         g_cyc = -100; mwe = 1'b0; mown = 1'b0; madr = '0; mwd = '0; mrd = '0;
`ifdef IO_ARB_RR_EN
         mlast = 1'b1;
`endif
      end else begin
         in_acc  = (cyc == g_cyc + 1);
         in_done = (cyc == g_cyc + 2);
         check("ctrl", {arb_busy, dma_io_we, m0_ack, m1_ack},
               {in_acc | in_done, in_acc & mwe, in_done & ~mown, in_done & mown});
         check("bus", {dma_io_wadr, dma_io_radr, dma_io_wdata}, {madr, madr, mwd});
         check("rdata", {m0_rdata, m1_rdata}, {mrd, mrd});
         if (dma_io_we) begin
            we_cnt++; last_wadr = dma_io_wadr; last_wdata = dma_io_wdata;
         end
         if (m0_ack) begin
            ack_cnt0++; ack_cyc0 = cyc; last_rd0 = m0_rdata;
            ack_order.push_back(0); ackc_log0.push_back(cyc); rd_log0.push_back(m0_rdata);
         end
         if (m1_ack) begin
            ack_cnt1++; last_rd1 = m1_rdata; ack_order.push_back(1);
         end
         if (!in_acc && !in_done && (m0_req || m1_req)) begin
`ifdef IO_ARB_RR_EN
            if (m0_req && m1_req) win = ~mlast;
            else                  win = m1_req;
            mlast = win;
`else
            win = ~m0_req;
`endif
            wwe  = win ? m1_we    : m0_we;
            wadr = win ? m1_adr   : m0_adr;
            wwd  = win ? m1_wdata : m0_wdata;
            g_cyc = cyc; mown = win; mwe = wwe; madr = wadr; mwd = wwd;
         end else if (in_acc) begin
            if (mwe) begin
               mrd = 16'h0000;
               shadow[madr] = mwd;
               shw[madr]    = 1'b1;
            end else begin
               mrd = shw[madr] ? shadow[madr] : {madr, 2'b00};
            end
         end
      end
   end

   task automatic push0(input logic we, input logic [15:2] adr, input logic [15:0] wd, input int gap, input bit gl);
      cmd_t c;
      c.we = we; c.adr = adr; c.wdata = wd; c.gap = gap; c.glitch = gl;
      q0.push_back(c);
   endtask

   task automatic push1(input logic we, input logic [15:2] adr, input logic [15:0] wd, input int gap, input bit gl);
      cmd_t c;
      c.we = we; c.adr = adr; c.wdata = wd; c.gap = gap; c.glitch = gl;
      q1.push_back(c);
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || m0_req || m1_req || arb_busy) && n < 5000) begin
         @(posedge clk); #2;
         n++;
      end
      check({name, "_done"}, 64'(n < 5000), 64'd1);
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!arb_busy && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      check({name, "_busy"}, 64'(arb_busy), 64'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

`ifdef IO_ARB_RR_EN
   int exp_own[4] = '{0, 1, 0, 1};
`else
   int exp_own[4] = '{0, 0, 0, 0};
`endif

   initial begin
      int req_cyc, w0, c0, c1;
      rst_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_wdata = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset_busy", arb_busy, 0);
      check("reset_we", dma_io_we, 0);
      check("reset_wadr", dma_io_wadr, 0);
      check("reset_acks", {m0_ack, m1_ack}, 0);
      #1 rst_n = 1'b1;

      // m0 write of 0005 to 3F80
      w0 = we_cnt;
      push0(1'b1, 14'h3F80, 16'h0005, 0, 1'b0);
      @(posedge clk); #2;
      req_cyc = cyc;
      wait_quiet("wr");
      check("wr_strobes", we_cnt - w0, 1);
      check("wr_wadr", last_wadr, 14'h3F80);
      check("wr_wdata", last_wdata, 16'h0005);
      check("wr_ack_lat", ack_cyc0 - req_cyc, 2);

      // m1 read back of 3F80
      w0 = we_cnt; c1 = ack_cnt1;
      push1(1'b0, 14'h3F80, 16'h0000, 0, 1'b0);
      wait_quiet("rd");
      check("rd_acks", ack_cnt1 - c1, 1);
      check("rd_data", last_rd1, 16'h0005);
      check("rd_no_we", we_cnt - w0, 0);

      // m0 back-to-back reads
      ackc_log0.delete(); rd_log0.delete();
      push0(1'b0, 14'h0010, 16'h0000, 0, 1'b0);
      push0(1'b0, 14'h0014, 16'h0000, 0, 1'b0);
      wait_quiet("b2b");
      check("b2b_n", ackc_log0.size(), 2);
      if (ackc_log0.size() == 2) begin
         check("b2b_gap", ackc_log0[1] - ackc_log0[0], 3);
         check("b2b_rd0", rd_log0[0], 16'h0040);
         check("b2b_rd1", rd_log0[1], 16'h0050);
      end

      // m1 request that appears and vanishes while the bus is busy
      c1 = ack_cnt1;
      push0(1'b0, 14'h0020, 16'h0000, 0, 1'b0);
      wait_busy("glitch");
      push1(1'b1, 14'h0030, 16'hDEAD, 0, 1'b1);
      wait_quiet("glitch");
      check("glitch_no_ack", ack_cnt1 - c1, 0);
      check("glitch_no_wr", pwr[14'h0030], 0);

      // reset pulse in the ACCESS cycle of an m0 write
      c0 = ack_cnt0; w0 = we_cnt;
      push0(1'b1, 14'h0123, 16'hBEEF, 0, 1'b0);
      wait_busy("abort");
      check("abort_we_pre", dma_io_we, 1);
      rst_n = 1'b0;
      #1;
      check("abort_we", dma_io_we, 0);
      check("abort_busy", arb_busy, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      wait_quiet("abort");
      check("abort_acks", ack_cnt0 - c0, 1);
      check("abort_strobes", we_cnt - w0, 1);
      check("abort_retry", pmem[14'h0123], 16'hBEEF);

      // both masters requesting continuously right after reset
      do_reset();
      ack_order.delete();
      for (int i = 0; i < 4; i++) begin
         push0(1'b0, 14'h0040 + 14'(i), 16'h0000, 0, 1'b0);
         push1(1'b0, 14'h0080 + 14'(i), 16'h0000, 0, 1'b0);
      end
      wait_quiet("conflict");
      check("own_n", ack_order.size(), 8);
      if (ack_order.size() == 8) begin
         for (int i = 0; i < 4; i++) check($sformatf("own_%0d", i), ack_order[i], exp_own[i]);
      end

      // random traffic from both masters against the model
      for (int i = 0; i < 150; i++) begin
         push0(1'($urandom_range(0, 1)), 14'h0100 + 14'($urandom_range(0, 7)), 16'($urandom),
               int'($urandom_range(0, 3)), 1'b0);
         push1(1'($urandom_range(0, 1)), 14'h0100 + 14'($urandom_range(0, 7)), 16'($urandom),
               int'($urandom_range(0, 3)), 1'b0);
      end
      wait_quiet("random");

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
